put_block: RTL and testbench
============================

# put_block

Writes a J×K block back into a row-major matrix buffer, one element per memory access. It is the write-side counterpart of the block gather used by the matmul datapath. It stores computed tiles (overwrite) or adds partial sums into an existing result tile (accumulate) through a single-port synchronous memory interface. Elements that fall outside the matrix bounds are clipped, so edge tiles need no special handling upstream.

## Interface
- `DATA_W`, default `DATA_W` macro (16): element width.
- `J`, default `J` macro (2): block rows.
- `K`, default `K` macro (2): block columns.
- `ADDR_W`, default 10: memory address width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low; one clock, one reset domain.
- `start`  in  1  request; sampled only while `busy`=0.
- `accumulate`  in  1  1 = read-modify-write add, 0 = overwrite; latched at start.
- `start_row`, `start_col`  in  10  block origin in the matrix; latched at start.
- `num_rows`, `num_cols`  in  10  matrix dimensions; `num_cols` is the row stride; latched at start.
- `block_in`  in  J*K*DATA_W  element (i,j) at bits `[(i*K+j)*DATA_W +: DATA_W]`; latched at start.
- `mem_addr`  out  ADDR_W  element address.
- `mem_re`  out  1  read strobe; data is returned on `mem_rdata` the next cycle.
- `mem_rdata`  in  DATA_W  read data.
- `mem_we`  out  1  write strobe.
- `mem_wdata`  out  DATA_W  write data.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE/DONE with `start`=1:
  - latch all inputs;
  - element index e=0, where e=i*K+j, row-major order;
  - go to RD if `accumulate`, else WR.
- Address: `mem_addr = ((start_row+i)*num_cols + start_col + j)` truncated to ADDR_W bits; it wraps modulo 2^ADDR_W with no error.
- Clipping: if `start_row+i >= num_rows` or `start_col+j >= num_cols`, the element is skipped. It still consumes its normal cycles, but `mem_re` and `mem_we` stay 0.
- RD (accumulate only): `mem_re`=1 with the element address, then go to WR.
- WR:
  - `mem_we`=1 with the same address;
  - `mem_wdata` = element (overwrite) or `mem_rdata` + element (accumulate), truncated to DATA_W, i.e. wraps modulo 2^DATA_W;
  - if e = J*K−1, go to DONE; otherwise e+1 and go to RD (accumulate) or WR (overwrite).
- DONE: `done`=1 for one cycle. Then IDLE, unless `start`=1, which begins a new transfer directly.
- `start` while `busy`=1 is ignored; no queuing.
- `num_cols`=0 or `num_rows`=0: every element is clipped. The transfer still runs its full length and pulses `done`.
- `mem_addr`/`mem_wdata` are 0 whenever the corresponding strobe is 0.

## Timing
- Reset (`rst`=0 at an edge): state IDLE. All outputs are 0: `busy`, `done`, `mem_re`, `mem_we`, `mem_addr`, `mem_wdata`. Latched registers are cleared.
- Reset mid-transfer aborts immediately. No further strobes follow, and elements already written are not restored.
- Cycle 0 = edge sampling `start`. Outputs are registered.
- Overwrite: element e is written in cycle e+1; `done` is high in cycle J*K+1.
- Accumulate: element e has RD in cycle 2e+1 and WR in cycle 2e+2; `done` is high in cycle 2*J*K+1.
- `busy`=1 from cycle 1 through the last WR cycle; it is 0 in the DONE cycle.
- A start accepted in the DONE cycle puts its first access in the next cycle, giving back-to-back throughput with no bubble.
- Memory read latency is fixed at 1 cycle. RD and WR of the same element use the same address.

## Test plan
- Overwrite, J=K=2, 4×4 matrix, origin (1,1), block {1,2,3,4} -> writes addr 5,6,9,10 = 1,2,3,4 in cycles 1–4; `done` in cycle 5; `busy` high cycles 1–4.
- Accumulate, memory all 10, origin (0,0), block {1,2,3,4} -> `mem_re` in cycles 1,3,5,7; writes addr 0,1,4,5 = 11,12,13,14 in cycles 2,4,6,8; `done` in cycle 9.
- Clipping, 4×4 matrix, origin (3,3), block {7,8,9,10} -> only addr 15 = 7 written (cycle 1); cycles 2–4 have no strobes; `done` in cycle 5.
- Wrap, accumulate, memory[0]=0xFFFF, element 2 -> write 0x0001; `mem_wdata` upper bits never exceed DATA_W.
- Reset: `rst`=0 in cycle 3 of an overwrite -> only addr of elements 0–1 written; from the next cycle all outputs 0, state IDLE; a fresh `start` then behaves as in the first scenario.
- `start` pulsed in cycle 2 of a transfer -> ignored, no extra writes. `start` held in the DONE cycle -> second transfer's first write in the following cycle.

Source files
------------

// File: rtl/put_block.sv
// put_block: writes a J x K block into a row-major matrix buffer, one element
// per memory access, either overwriting or accumulating into existing data.
// Elements outside the matrix bounds still take their cycles but issue no strobes.

`ifndef DATA_W
`define DATA_W 16
`endif
`ifndef J
`define J 2
`endif
`ifndef K
`define K 2
`endif

module put_block #(
  parameter int DATA_W = `DATA_W,
  parameter int J      = `J,
  parameter int K      = `K,
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    accumulate,
  input  logic [9:0]              start_row,
  input  logic [9:0]              start_col,
  input  logic [9:0]              num_rows,
  input  logic [9:0]              num_cols,
  input  logic [J*K*DATA_W-1:0]   block_in,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_re,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    mem_we,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  localparam logic [9:0] I_LAST = 10'(J - 1);
  localparam logic [9:0] J_LAST = 10'(K - 1);

  state_t                  state_q, state_d;
  logic                    acc_q, acc_d;
  logic [9:0]              srow_q, srow_d;
  logic [9:0]              scol_q, scol_d;
  logic [9:0]              nrows_q, nrows_d;
  logic [9:0]              ncols_q, ncols_d;
  logic [J*K*DATA_W-1:0]   blk_q, blk_d;
  logic [9:0]              i_q, i_d;
  logic [9:0]              j_q, j_d;

  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    re_q, re_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       elem_q, elem_d;

  logic [10:0]             row_sum;
  logic [10:0]             col_sum;
  logic                    in_range;
  logic [31:0]             addr_full;
  logic [DATA_W-1:0]       elem_sel;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: transfer sequencing, input latching and element stepping
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    srow_d  = srow_q;
    scol_d  = scol_q;
    nrows_d = nrows_q;
    ncols_d = ncols_q;
    blk_d   = blk_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          acc_d   = accumulate;
          srow_d  = start_row;
          scol_d  = start_col;
          nrows_d = num_rows;
          ncols_d = num_cols;
          blk_d   = block_in;
          i_d     = '0;
          j_d     = '0;
          state_d = accumulate ? S_RD : S_WR;
        end
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        if (i_q == I_LAST && j_q == J_LAST) begin
          state_d = S_DONE;
        end else begin
          if (j_q == J_LAST) begin
            j_d = '0;
            i_d = i_q + 10'd1;
          end else begin
            j_d = j_q + 10'd1;
          end
          state_d = acc_q ? S_RD : S_WR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next-cycle strobes, address and element, computed from the next state
  always_comb begin
    row_sum   = {1'b0, srow_d} + {1'b0, i_d};
    col_sum   = {1'b0, scol_d} + {1'b0, j_d};
    in_range  = (row_sum < {1'b0, nrows_d}) && (col_sum < {1'b0, ncols_d});
    addr_full = 32'(row_sum) * 32'(ncols_d) + 32'(col_sum);
    elem_sel  = '0;
    for (int ii = 0; ii < J; ii++) begin
      for (int jj = 0; jj < K; jj++) begin
        if (i_d == 10'(ii) && j_d == 10'(jj))
          elem_sel = blk_d[(ii*K + jj)*DATA_W +: DATA_W];
      end
    end
    busy_d = (state_d == S_RD) || (state_d == S_WR);
    done_d = (state_d == S_DONE);
    re_d   = (state_d == S_RD) && in_range;
    we_d   = (state_d == S_WR) && in_range;
    addr_d = (re_d || we_d) ? addr_full[ADDR_W-1:0] : '0;
    elem_d = we_d ? elem_sel : '0;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q   <= 1'b0;
      srow_q  <= '0;
      scol_q  <= '0;
      nrows_q <= '0;
      ncols_q <= '0;
      blk_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      elem_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      srow_q  <= srow_d;
      scol_q  <= scol_d;
      nrows_q <= nrows_d;
      ncols_q <= ncols_d;
      blk_q   <= blk_d;
      i_q     <= i_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      re_q    <= re_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      elem_q  <= elem_d;
    end
  end

  // Read data arrives in the WR cycle, so the accumulate add sits after the flops
  assign mem_wdata = we_q ? (acc_q ? elem_q + mem_rdata : elem_q) : '0;
  assign mem_addr  = addr_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_put_block.sv
// Bench for put_block: per-cycle expected outputs are pushed to a queue when
// a transfer is launched and popped against the DUT one cycle at a time.

module tb_put_block;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        accumulate = 1'b0;
  logic [9:0]  start_row = '0, start_col = '0, num_rows = '0, num_cols = '0;
  logic [63:0] block_in = '0;
  logic [9:0]  mem_addr;
  logic        mem_re, mem_we, busy, done;
  logic [15:0] mem_rdata = '0;
  logic [15:0] mem_wdata;

  logic [15:0] mem [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic        fill_req = 1'b0;
  logic [15:0] fill_val = '0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        re;
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wdata;
  } obs_t;

  obs_t exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  put_block #(.DATA_W(16), .J(2), .K(2), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
    .start_row(start_row), .start_col(start_col),
    .num_rows(num_rows), .num_cols(num_cols), .block_in(block_in),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  // Single-port synchronous memory, 1-cycle read latency
  always @(posedge clk) begin
    if (fill_req) begin
      for (int a = 0; a < 1024; a++) mem[a] <= fill_val;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  function automatic obs_t actual();
    obs_t o;
    o.busy = busy; o.done = done; o.re = mem_re; o.we = mem_we;
    o.addr = mem_addr; o.wdata = mem_wdata;
    return o;
  endfunction

  task automatic fill_mem(input logic [15:0] v);
    fill_val = v;
    fill_req = 1'b1;
    for (int a = 0; a < 1024; a++) ref_mem[a] = v;
    @(posedge clk);
    #1 fill_req = 1'b0;
  endtask

  // Reference model: one expected observation per cycle from cycle 1 to done
  task automatic build_expect(input bit acc, input int sr, input int sc,
                              input int nr, input int nc, input logic [63:0] blk);
    obs_t o;
    logic [15:0] el, d;
    int ad;
    bit inr;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        inr = (sr + i < nr) && (sc + j < nc);
        ad  = ((sr + i) * nc + sc + j) % 1024;
        el  = blk[(i*2 + j)*16 +: 16];
        if (acc) begin
          o = '0; o.busy = 1'b1; o.re = inr;
          if (inr) o.addr = ad[9:0];
          exp_q.push_back(o);
        end
        o = '0; o.busy = 1'b1; o.we = inr;
        if (inr) begin
          d = acc ? 16'(ref_mem[ad] + el) : el;
          o.addr = ad[9:0];
          o.wdata = d;
          ref_mem[ad] = d;
        end
        exp_q.push_back(o);
      end
    end
    o = '0; o.done = 1'b1;
    exp_q.push_back(o);
  endtask

  // Drive one start request (caller is at a negedge) and record its expectations
  task automatic kick(input bit acc, input int sr, input int sc,
                      input int nr, input int nc, input logic [63:0] blk);
    accumulate = acc;
    start_row = 10'(sr); start_col = 10'(sc);
    num_rows = 10'(nr); num_cols = 10'(nc);
    block_in = blk;
    start = 1'b1;
    build_expect(acc, sr, sc, nr, nc, blk);
  endtask

  task automatic test_reset();
    obs_t a;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = actual(); tests_run++;
    if (a !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %h exp %h", a, obs_t'(0));
    end
    rst = 1'b1;
    @(negedge clk);
    a = actual(); tests_run++;
    if (a !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle got %h exp %h", a, obs_t'(0));
    end
  endtask

  task automatic test_overwrite(input string nm);
    obs_t e, a;
    int cyc = 0;
    fill_mem(16'h0);
    @(negedge clk);
    kick(0, 1, 1, 4, 4, {16'd4, 16'd3, 16'd2, 16'd1});
    while (exp_q.size() > 0) begin
      @(negedge clk); start = 1'b0; cyc++;
      e = exp_q.pop_front(); a = actual(); tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s cyc%0d got %h exp %h", nm, cyc, a, e);
      end
    end
  endtask

  task automatic test_accumulate();
    obs_t e, a;
    int cyc = 0;
    fill_mem(16'd10);
    @(negedge clk);
    kick(1, 0, 0, 4, 4, {16'd4, 16'd3, 16'd2, 16'd1});
    while (exp_q.size() > 0) begin
      @(negedge clk); start = 1'b0; cyc++;
      e = exp_q.pop_front(); a = actual(); tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL accumulate cyc%0d got %h exp %h", cyc, a, e);
      end
    end
  endtask

  task automatic test_clip();
    obs_t e, a;
    int cyc = 0;
    fill_mem(16'h0);
    @(negedge clk);
    kick(0, 3, 3, 4, 4, {16'd10, 16'd9, 16'd8, 16'd7});
    while (exp_q.size() > 0) begin
      @(negedge clk); start = 1'b0; cyc++;
      e = exp_q.pop_front(); a = actual(); tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL clip cyc%0d got %h exp %h", cyc, a, e);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e, a;
    int cyc = 0;
    fill_mem(16'hFFFF);
    @(negedge clk);
    kick(1, 0, 0, 1, 1, {16'hFFFF, 16'h8000, 16'h1234, 16'd2});
    while (exp_q.size() > 0) begin
      @(negedge clk); start = 1'b0; cyc++;
      e = exp_q.pop_front(); a = actual(); tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL wrap cyc%0d got %h exp %h", cyc, a, e);
      end
    end
    tests_run++;
    if (mem[0] !== 16'h0001) begin
      tests_failed++;
      $display("FAIL wrap_mem0 got %h exp %h", mem[0], 16'h0001);
    end
  endtask

  task automatic test_zero_dims();
    obs_t e, a;
    int cyc = 0;
    fill_mem(16'h0);
    @(negedge clk);
    kick(1, 2, 2, 0, 0, {16'd1, 16'd1, 16'd1, 16'd1});
    while (exp_q.size() > 0) begin
      @(negedge clk); start = 1'b0; cyc++;
      e = exp_q.pop_front(); a = actual(); tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL zero_dims cyc%0d got %h exp %h", cyc, a, e);
      end
    end
  endtask

  task automatic test_reset_midway();
    obs_t e, a;
    int cyc = 0;
    logic [63:0] got;
    fill_mem(16'h0);
    @(negedge clk);
    kick(0, 1, 1, 4, 4, {16'd4, 16'd3, 16'd2, 16'd1});
    while (cyc < 2) begin
      @(negedge clk); start = 1'b0; cyc++;
      e = exp_q.pop_front(); a = actual(); tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL reset_mid cyc%0d got %h exp %h", cyc, a, e);
      end
    end
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    a = actual(); tests_run++;
    if (a !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_abort got %h exp %h", a, obs_t'(0));
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    a = actual(); tests_run++;
    if (a !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_idle got %h exp %h", a, obs_t'(0));
    end
    got = {mem[10], mem[9], mem[6], mem[5]};
    tests_run++;
    if (got !== {16'd0, 16'd0, 16'd2, 16'd1}) begin
      tests_failed++;
      $display("FAIL reset_mid_mem got %h exp %h", got, {16'd0, 16'd0, 16'd2, 16'd1});
    end
  endtask

  task automatic test_start_ignored();
    obs_t e, a;
    int cyc = 0;
    fill_mem(16'h0);
    @(negedge clk);
    kick(0, 0, 0, 4, 4, {16'd44, 16'd33, 16'd22, 16'd11});
    while (exp_q.size() > 0) begin
      @(negedge clk); start = 1'b0; cyc++;
      e = exp_q.pop_front(); a = actual(); tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL start_ignored cyc%0d got %h exp %h", cyc, a, e);
      end
      if (cyc == 2) begin
        start_row = 10'd2; block_in = {4{16'hDEAD}};
        start = 1'b1;
      end
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      a = actual(); tests_run++;
      if (a !== '0) begin
        tests_failed++;
        $display("FAIL start_ignored_idle%0d got %h exp %h", n, a, obs_t'(0));
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    int cyc = 0;
    bit launched = 1'b0;
    fill_mem(16'd5);
    @(negedge clk);
    kick(0, 0, 0, 2, 2, {16'd4, 16'd3, 16'd2, 16'd1});
    while (exp_q.size() > 0) begin
      @(negedge clk); start = 1'b0; cyc++;
      e = exp_q.pop_front(); a = actual(); tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL back_to_back cyc%0d got %h exp %h", cyc, a, e);
      end
      if (e.done && !launched) begin
        launched = 1'b1;
        kick(1, 0, 0, 2, 2, {16'd40, 16'd30, 16'd20, 16'd10});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_overwrite("overwrite");
    test_accumulate();
    test_clip();
    test_wrap();
    test_zero_dims();
    test_reset_midway();
    test_overwrite("after_reset");
    test_start_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
